player_lives: RTL
=================

# player_lives

Consumer of the per-frame collision pulses produced by the hit detector. It watches the player-hit bits of `HitPulse` and keeps the player's life count. After each hit it runs a frame-counted invulnerability window with sprite blinking, and it latches game-over. It sits between hit detection and the player drawing/movement logic and the game-state controller.

## Interface
Parameters:
- `COLLISION_WIDTH`, 7: width of the incoming hit-pulse vector.
- `PLAYER_MISSILE_BIT`, 4: index of the player-vs-enemy-missile pulse.
- `PLAYER_ENEMY_BIT`, 6: index of the player-vs-enemy-body pulse.
- `LIVES_WIDTH`, 3: width of the life counter.
- `INITIAL_LIVES`, 3: lives loaded at reset and at `new_game`. Must be ≥1.
- `MAX_LIVES`, 5: saturation cap for bonus lives. Must be ≥`INITIAL_LIVES` and <2^`LIVES_WIDTH`.
- `INVULN_FRAMES`, 60: length of the invulnerability window in frames. Must be ≥1.
- `BLINK_FRAMES`, 4: frames per visibility half-period while invulnerable. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `startOfFrame`  in  1  one-cycle pulse at the start of each frame.
- `HitPulse`  in  `COLLISION_WIDTH`  one-cycle collision pulses, at most one per bit per frame.
- `new_game`  in  1  one-cycle restart request.
- `bonus_life`  in  1  one-cycle request to add one life. Present only with `PLAYER_BONUS_LIFE_EN`.
- `lives`  out  `LIVES_WIDTH`  current life count.
- `invulnerable`  out  1  high while the invulnerability window is active.
- `player_visible`  out  1  draw enable for the player sprite.
- `life_lost`  out  1  one-cycle pulse for each accepted hit.
- `game_over`  out  1  level signal, high in GAME_OVER.

## Operation
- Hit condition: `hit = HitPulse[PLAYER_MISSILE_BIT] | HitPulse[PLAYER_ENEMY_BIT]`. Both bits together count as a single hit.
- States and transitions:
  - ALIVE:
    - On `hit`: `lives` decrements by 1 and `life_lost` pulses.
    - If `lives` was 1, go to GAME_OVER.
    - Otherwise go to INVULN: frame counter loads `INVULN_FRAMES`, blink counter loads `BLINK_FRAMES`, `player_visible` goes to 0.
  - INVULN:
    - `hit` is ignored: no decrement, no pulse.
    - Each `startOfFrame` decrements the frame counter and the blink counter.
    - When the blink counter reaches 0, `player_visible` toggles and the blink counter reloads.
    - When the frame counter reaches 0, go to ALIVE with `player_visible` = 1.
  - GAME_OVER: `lives` = 0, `player_visible` = 0, `game_over` = 1. Everything except `new_game` and `reset` is ignored.
- `new_game` in any state: go to ALIVE, `lives` = `INITIAL_LIVES`, counters cleared, `player_visible` = 1, `invulnerable` = 0, `game_over` = 0, no `life_lost` pulse.
- Priority (highest first): `reset`, `new_game`, `hit`, `startOfFrame`.
- `hit` and `startOfFrame` in the same cycle while ALIVE: the hit is processed. The frame tick is not counted against the new window.
- `invulnerable` is 1 exactly while in INVULN.
- `lives` never wraps: it is never decremented below 0 and never incremented above `MAX_LIVES`.

## Timing
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N (1-cycle latency).
- `life_lost` is high for exactly one cycle per accepted hit.
- The invulnerability window spans exactly `INVULN_FRAMES` `startOfFrame` pulses after the hit. The transition to ALIVE is taken on the edge that samples the `INVULN_FRAMES`-th pulse.
- A hit arriving in the cycle right after the INVULN→ALIVE transition is accepted.
- Reset values: `lives` = `INITIAL_LIVES`, state ALIVE, `invulnerable` = 0, `player_visible` = 1, `life_lost` = 0, `game_over` = 0, both counters = 0.
- Reset asserted mid-window or in GAME_OVER restores all reset values on the next edge.

## Configuration
- `PLAYER_BONUS_LIFE_EN` defined:
  - The `bonus_life` port exists.
  - In ALIVE or INVULN a `bonus_life` pulse increments `lives`, saturating at `MAX_LIVES`.
  - It is ignored in GAME_OVER and when `new_game` is asserted in the same cycle.
  - `hit` and `bonus_life` in the same cycle while ALIVE: net `lives` is unchanged, `life_lost` pulses, and the block enters INVULN. This applies even when `lives` = 1, so no GAME_OVER occurs.
- Not defined: no `bonus_life` port, `lives` never increases except by `new_game`, and `MAX_LIVES` is unused.

## Test plan
- Reset, then pulse `HitPulse[4]` once → after one cycle `lives` = 2, `life_lost` high for 1 cycle, `invulnerable` = 1, `player_visible` = 0.
- In INVULN, pulse `HitPulse[6]` → `lives` stays 2 and no `life_lost` pulse. After 60 `startOfFrame` pulses → `invulnerable` = 0, `player_visible` = 1. `player_visible` toggles every 4 frames during the window.
- From 1 life, pulse `HitPulse[4]` and `HitPulse[6]` together in one cycle → a single `life_lost` pulse, `lives` = 0, `game_over` = 1. Further hits do nothing. `new_game` → `lives` = 3, `game_over` = 0.
- ALIVE with `hit` and `startOfFrame` in the same cycle → block enters INVULN and exactly 60 further frames are required to leave it.
- `reset` asserted mid-INVULN with `lives` = 1 → next cycle `lives` = 3, ALIVE, `player_visible` = 1.
- With `PLAYER_BONUS_LIFE_EN`: 3 `bonus_life` pulses from 3 lives → `lives` = 5 (saturated). `bonus_life` with `hit` at `lives` = 1 → `lives` = 1, INVULN, `game_over` = 0.

Source files
------------

// File: rtl/player_lives.sv
// Player life counter with post-hit invulnerability window, sprite blinking and game-over latch.
// Optional feature: define PLAYER_BONUS_LIFE_EN to add the bonus_life input (saturating at MAX_LIVES).
module player_lives #(
    parameter int COLLISION_WIDTH    = 7,
    parameter int PLAYER_MISSILE_BIT = 4,
    parameter int PLAYER_ENEMY_BIT   = 6,
    parameter int LIVES_WIDTH        = 3,
    parameter int INITIAL_LIVES      = 3,
    parameter int MAX_LIVES          = 5,
    parameter int INVULN_FRAMES      = 60,
    parameter int BLINK_FRAMES       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic [COLLISION_WIDTH-1:0] HitPulse,
    input  logic                       new_game,
`ifdef PLAYER_BONUS_LIFE_EN
    input  logic                       bonus_life,
`endif
    output logic [LIVES_WIDTH-1:0]     lives,
    output logic                       invulnerable,
    output logic                       player_visible,
    output logic                       life_lost,
    output logic                       game_over
);

    localparam int FRAME_W = $clog2(INVULN_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {ALIVE, INVULN, GAME_OVER} state_t;

    state_t             state;
    logic [FRAME_W-1:0] frame_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               hit;
    logic               bonus;
    logic               unused_hit_bits;

    assign hit             = HitPulse[PLAYER_MISSILE_BIT] | HitPulse[PLAYER_ENEMY_BIT];
    assign unused_hit_bits = ^HitPulse;

`ifdef PLAYER_BONUS_LIFE_EN
    assign bonus = bonus_life;
`else
    assign bonus = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state          <= ALIVE;
            lives          <= LIVES_WIDTH'(INITIAL_LIVES);
            frame_cnt      <= '0;
            blink_cnt      <= '0;
            invulnerable   <= 1'b0;
            player_visible <= 1'b1;
            life_lost      <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            life_lost <= 1'b0;
            case (state)
                ALIVE: begin
                    if (hit) begin
                        life_lost <= 1'b1;
                        // A simultaneous bonus cancels the decrement, so even the last life survives.
                        if (bonus || lives > LIVES_WIDTH'(1)) begin
                            if (!bonus)
                                lives <= lives - LIVES_WIDTH'(1);
                            state          <= INVULN;
                            frame_cnt      <= FRAME_W'(INVULN_FRAMES);
                            blink_cnt      <= BLINK_W'(BLINK_FRAMES);
                            invulnerable   <= 1'b1;
                            player_visible <= 1'b0;
                        end else begin
                            state          <= GAME_OVER;
                            lives          <= '0;
                            player_visible <= 1'b0;
                            game_over      <= 1'b1;
                        end
                    end else if (bonus && lives < LIVES_WIDTH'(MAX_LIVES)) begin
                        lives <= lives + LIVES_WIDTH'(1);
                    end
                end
                INVULN: begin
                    if (bonus && lives < LIVES_WIDTH'(MAX_LIVES))
                        lives <= lives + LIVES_WIDTH'(1);
                    if (startOfFrame) begin
                        if (frame_cnt <= FRAME_W'(1)) begin
                            state          <= ALIVE;
                            frame_cnt      <= '0;
                            blink_cnt      <= '0;
                            invulnerable   <= 1'b0;
                            player_visible <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt - FRAME_W'(1);
                            if (blink_cnt <= BLINK_W'(1)) begin
                                blink_cnt      <= BLINK_W'(BLINK_FRAMES);
                                player_visible <= ~player_visible;
                            end else begin
                                blink_cnt <= blink_cnt - BLINK_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    lives          <= '0;
                    player_visible <= 1'b0;
                    game_over      <= 1'b1;
                    invulnerable   <= 1'b0;
                end
            endcase
        end
    end

endmodule
